// File: rtl/muldiv_sched_pkg.sv
// Shared encodings and state types for the mul/div scheduler.
package muldiv_sched_pkg;

    localparam int MUL_LAT = 2;

    localparam logic [2:0] MD_MUL   = 3'd0;
    localparam logic [2:0] MD_MULH  = 3'd1;
    localparam logic [2:0] MD_MULHU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_MOD   = 3'd4;
    localparam logic [2:0] MD_DIVU  = 3'd5;
    localparam logic [2:0] MD_MODU  = 3'd6;

    typedef enum logic [1:0] {P_FREE, P_WAIT, P_HAVE} port_state_t;
    typedef enum logic [1:0] {D_IDLE, D_START, D_BUSY, D_DRAIN} div_state_t;
    typedef enum logic {M_IDLE, M_EXEC} mul_state_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return op <= MD_MULHU;
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op >= MD_DIV) && (op <= MD_MODU);
    endfunction

endpackage

// File: rtl/muldiv_sched_rr_arb2.sv
// Two-requester round-robin arbiter; pointer moves past the winner on advance.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_reg;

    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = ptr_reg ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_reg <= 1'b0;
        else if (advance)
            ptr_reg <= grant[0];
    end

endmodule

// File: rtl/muldiv_sched.sv
// Arbitrates two issue pipes onto one 2-cycle multiplier and one iterative divider.
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int NPORT = 2,
    parameter int OPW   = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NPORT-1:0]            req_valid,
    output logic [NPORT-1:0]            req_ready,
    input  logic [NPORT-1:0][OPW-1:0]   req_op,
    input  logic [NPORT-1:0][31:0]      req_src1,
    input  logic [NPORT-1:0][31:0]      req_src2,
    input  logic [NPORT-1:0]            flush,
    output logic [NPORT-1:0]            resp_valid,
    input  logic [NPORT-1:0]            resp_ready,
    output logic [NPORT-1:0][31:0]      resp_result,
    output logic [31:0]                 mul_op1,
    output logic [31:0]                 mul_op2,
    output logic                        mul_sign,
    input  logic [63:0]                 mul_out,
    output logic                        div_en,
    output logic                        div_sign,
    output logic [31:0]                 div_op1,
    output logic [31:0]                 div_op2,
    input  logic                        div_ready,
    input  logic                        div_complete,
    input  logic [31:0]                 div_rem,
    input  logic [31:0]                 div_quo
);

    port_state_t              pstate_reg [NPORT];
    logic [NPORT-1:0]         zpend_reg;
    logic [NPORT-1:0][31:0]   result_reg;

    mul_state_t  m_state_reg, m_state_next;
    logic [1:0]  m_cnt_reg;
    logic [31:0] m_a_reg, m_b_reg;
    logic [2:0]  m_op_reg;
    logic        m_sign_reg, m_port_reg, m_live_reg;

    div_state_t  d_state_reg, d_state_next;
    logic [31:0] d_a_reg, d_b_reg;
    logic [2:0]  d_op_reg;
    logic        d_sign_reg, d_port_reg;

    logic [NPORT-1:0] mul_req, div_req, mul_grant, div_grant, mul_take, div_take, src_zero;
    logic             mul_avail, div_avail, mul_last, mul_cap, div_cap, mul_sel, div_sel;
    logic [31:0]      mul_res, div_res;

    assign mul_last  = (m_state_reg == M_EXEC) && (m_cnt_reg == 2'(MUL_LAT - 1));
    assign mul_avail = (m_state_reg == M_IDLE) || mul_last;
    assign div_avail = (d_state_reg == D_IDLE) && div_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_port
            assign mul_req[gi]     = req_valid[gi] && (pstate_reg[gi] == P_FREE) &&
                                     is_mul_op(req_op[gi]) && mul_avail;
            assign div_req[gi]     = req_valid[gi] && (pstate_reg[gi] == P_FREE) &&
                                     is_div_op(req_op[gi]) && div_avail;
            assign src_zero[gi]    = (req_src1[gi] == '0) || (req_src2[gi] == '0);
            assign resp_valid[gi]  = (pstate_reg[gi] == P_HAVE);
            assign resp_result[gi] = result_reg[gi];
        end
    endgenerate

    rr_arb2 u_mul_arb (.clk(clk), .rst(rst), .req(mul_req), .advance(|mul_take), .grant(mul_grant));
    rr_arb2 u_div_arb (.clk(clk), .rst(rst), .req(div_req), .advance(|div_take), .grant(div_grant));

    // A flush in the grant cycle cancels the grant before it reaches the arbiter pointer.
    assign mul_take  = mul_grant & ~flush;
    assign div_take  = div_grant & ~flush;
    assign req_ready = mul_take | div_take;
    assign mul_sel   = mul_take[1];
    assign div_sel   = div_take[1];

    assign mul_op1  = (m_state_reg == M_EXEC) ? m_a_reg : '0;
    assign mul_op2  = (m_state_reg == M_EXEC) ? m_b_reg : '0;
    assign mul_sign = (m_state_reg == M_EXEC) && m_sign_reg;
    assign mul_cap  = mul_last && m_live_reg && !flush[m_port_reg];
    assign mul_res  = (m_op_reg == MD_MUL) ? mul_out[31:0] : mul_out[63:32];

    always_comb begin
        m_state_next = m_state_reg;
        case (m_state_reg)
            M_IDLE:  if (|mul_take) m_state_next = M_EXEC;
            M_EXEC:  if (mul_last && !(|mul_take)) m_state_next = M_IDLE;
            default: m_state_next = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state_reg <= M_IDLE;
            m_cnt_reg   <= '0;
            m_a_reg     <= '0;
            m_b_reg     <= '0;
            m_op_reg    <= '0;
            m_sign_reg  <= 1'b0;
            m_port_reg  <= 1'b0;
            m_live_reg  <= 1'b0;
        end else begin
            m_state_reg <= m_state_next;
            if (|mul_take) begin
                m_cnt_reg  <= '0;
                m_a_reg    <= req_src1[mul_sel];
                m_b_reg    <= req_src2[mul_sel];
                m_op_reg   <= req_op[mul_sel];
                m_sign_reg <= (req_op[mul_sel] != MD_MULHU);
                m_port_reg <= mul_sel;
                m_live_reg <= 1'b1;
            end else begin
                if (m_state_reg == M_EXEC)
                    m_cnt_reg <= m_cnt_reg + 2'd1;
                if (flush[m_port_reg])
                    m_live_reg <= 1'b0;
            end
        end
    end

    assign div_en   = (d_state_reg == D_START);
    assign div_op1  = d_a_reg;
    assign div_op2  = d_b_reg;
    assign div_sign = d_sign_reg;
    assign div_cap  = (d_state_reg == D_BUSY) && div_complete && !flush[d_port_reg];
    assign div_res  = ((d_op_reg == MD_DIV) || (d_op_reg == MD_DIVU)) ? div_quo : div_rem;

    // A flushed divide still owns the core until it reports completion.
    always_comb begin
        d_state_next = d_state_reg;
        case (d_state_reg)
            D_IDLE:  if ((|div_take) && !src_zero[div_sel]) d_state_next = D_START;
            D_START: d_state_next = flush[d_port_reg] ? D_DRAIN : D_BUSY;
            D_BUSY:  if (div_complete) d_state_next = D_IDLE;
                     else if (flush[d_port_reg]) d_state_next = D_DRAIN;
            D_DRAIN: if (div_complete) d_state_next = D_IDLE;
            default: d_state_next = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_state_reg <= D_IDLE;
            d_a_reg     <= '0;
            d_b_reg     <= '0;
            d_op_reg    <= '0;
            d_sign_reg  <= 1'b0;
            d_port_reg  <= 1'b0;
        end else begin
            d_state_reg <= d_state_next;
            if ((|div_take) && !src_zero[div_sel]) begin
                d_a_reg    <= req_src1[div_sel];
                d_b_reg    <= req_src2[div_sel];
                d_op_reg   <= req_op[div_sel];
                d_sign_reg <= (req_op[div_sel] == MD_DIV) || (req_op[div_sel] == MD_MOD);
                d_port_reg <= div_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NPORT; p++) begin
                pstate_reg[p] <= P_FREE;
                zpend_reg[p]  <= 1'b0;
                result_reg[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                zpend_reg[p] <= 1'b0;
                case (pstate_reg[p])
                    P_FREE: if (req_ready[p]) begin
                        pstate_reg[p] <= P_WAIT;
                        zpend_reg[p]  <= div_take[p] && src_zero[p];
                    end
                    P_WAIT: if (flush[p]) begin
                        pstate_reg[p] <= P_FREE;
                    end else if (zpend_reg[p]) begin
                        pstate_reg[p] <= P_HAVE;
                        result_reg[p] <= '0;
                    end else if (mul_cap && (m_port_reg == 1'(p))) begin
                        pstate_reg[p] <= P_HAVE;
                        result_reg[p] <= mul_res;
                    end else if (div_cap && (d_port_reg == 1'(p))) begin
                        pstate_reg[p] <= P_HAVE;
                        result_reg[p] <= div_res;
                    end
                    P_HAVE: if (flush[p] || resp_ready[p]) pstate_reg[p] <= P_FREE;
                    default: pstate_reg[p] <= P_FREE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched with behavioural multiplier and divider cores.
module tb_muldiv_sched;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid, req_ready, flush, resp_valid, resp_ready;
    logic [1:0][2:0]  req_op;
    logic [1:0][31:0] req_src1, req_src2, resp_result;
    logic [31:0]      mul_op1, mul_op2, div_op1, div_op2, div_rem, div_quo;
    logic             mul_sign, div_en, div_sign, div_ready, div_complete;
    logic [63:0]      mul_out;

    int tests = 0;
    int fails = 0;
    int den_cnt = 0;
    int cplt_cnt = 0;
    int rv0_cnt = 0;

    muldiv_sched #(.NPORT(2), .OPW(3)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_sign(mul_sign), .mul_out(mul_out),
        .div_en(div_en), .div_sign(div_sign), .div_op1(div_op1), .div_op2(div_op2),
        .div_ready(div_ready), .div_complete(div_complete),
        .div_rem(div_rem), .div_quo(div_quo)
    );

    always #5 clk = ~clk;

    always_comb begin
        mul_out = '0;
        if (mul_sign)
            mul_out = {{32{mul_op1[31]}}, mul_op1} * {{32{mul_op2[31]}}, mul_op2};
        else
            mul_out = {32'b0, mul_op1} * {32'b0, mul_op2};
    end

    logic        dv_busy, dv_s;
    logic [2:0]  dv_cnt;
    logic [31:0] dv_a, dv_b, dv_q, dv_r;

    always_comb begin
        dv_q = '0;
        dv_r = '0;
        if (dv_b != '0) begin
            if (dv_s) begin
                dv_q = $signed(dv_a) / $signed(dv_b);
                dv_r = $signed(dv_a) % $signed(dv_b);
            end else begin
                dv_q = dv_a / dv_b;
                dv_r = dv_a % dv_b;
            end
        end
    end

    assign div_ready = !dv_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_busy <= 1'b0; dv_cnt <= '0; dv_a <= '0; dv_b <= '0; dv_s <= 1'b0;
            div_complete <= 1'b0; div_quo <= '0; div_rem <= '0;
        end else begin
            div_complete <= 1'b0;
            if (!dv_busy && div_en) begin
                dv_busy <= 1'b1; dv_cnt <= 3'd4;
                dv_a <= div_op1; dv_b <= div_op2; dv_s <= div_sign;
            end else if (dv_busy) begin
                dv_cnt <= dv_cnt - 3'd1;
                if (dv_cnt == 3'd1) begin
                    dv_busy <= 1'b0; div_complete <= 1'b1;
                    div_quo <= dv_q; div_rem <= dv_r;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (div_en)        den_cnt  <= den_cnt + 1;
        if (div_complete)  cplt_cnt <= cplt_cnt + 1;
        if (resp_valid[0]) rv0_cnt  <= rv0_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int p, input string tag);
        int n = 0;
        while (resp_valid[p] !== 1'b1 && n < 40) begin
            tick(); #2; n++;
        end
        check(tag, 64'(n < 40), 64'd1);
    endtask

    task automatic wait_ready(input int p, input string tag);
        int n = 0;
        while (req_ready[p] !== 1'b1 && n < 40) begin
            tick(); #2; n++;
        end
        check(tag, 64'(n < 40), 64'd1);
    endtask

    initial begin
        int e0, e1, e2, r0;
        rst = 1'b1; req_valid = '0; req_op = '0; req_src1 = '0; req_src2 = '0;
        flush = '0; resp_ready = '0;
        tick(); #2;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_result", resp_result, 64'd0);
        check("rst_mul_ops", {mul_op1, mul_op2}, 64'd0);
        check("rst_div_ops", {div_op1, div_op2}, 64'd0);
        check("rst_ctl", {div_en, div_sign, mul_sign}, 64'd0);
        check("rst_ptrs", {u_dut.u_mul_arb.ptr_reg, u_dut.u_div_arb.ptr_reg}, 64'd0);
        tick(); rst = 1'b0;
        tick();

        // MUL 0xFFFFFFFF x 2 on port 0
        req_valid = 2'b01; req_op[0] = 3'd0; req_src1[0] = 32'hFFFF_FFFF; req_src2[0] = 32'd2;
        resp_ready = 2'b11;
        #2 check("mul_accept", 64'(req_ready), 64'd1);
        tick(); req_valid = '0;
        #2 check("mul_op_drive", {mul_op1, mul_op2}, {32'hFFFF_FFFF, 32'd2});
        tick(); #2 check("mul_not_early", 64'(resp_valid), 64'd0);
        tick(); #2 check("mul_result", {resp_valid, resp_result[0]}, {2'b01, 32'hFFFF_FFFE});
        tick(); #2 check("mul_idle_ops", {mul_op1, 30'd0, resp_valid}, 64'd0);

        // MULHU same operands
        req_valid = 2'b01; req_op[0] = 3'd2;
        #2 check("mulhu_accept", 64'(req_ready), 64'd1);
        tick(); req_valid = '0;
        #2 check("mulhu_sign", 64'(mul_sign), 64'd0);
        tick(); tick(); #2 check("mulhu_result", {resp_valid[0], resp_result[0]}, {1'b1, 32'h1});
        tick();

        // reserved op never accepted
        req_valid = 2'b01; req_op[0] = 3'd7;
        #2 check("op7_ready", 64'(req_ready), 64'd0);
        tick(); #2 check("op7_ready_hold", 64'(req_ready), 64'd0);
        tick(); req_valid = '0;

        // Port 0 DIV -7/2 and port 1 MULH 0x80000000 x 2 together
        req_valid = 2'b11;
        req_op[0] = 3'd3; req_src1[0] = 32'hFFFF_FFF9; req_src2[0] = 32'd2;
        req_op[1] = 3'd1; req_src1[1] = 32'h8000_0000; req_src2[1] = 32'd2;
        #2 check("div_mul_both_ready", 64'(req_ready), 64'd3);
        tick(); req_valid = '0;
        #2 check("div_start_pulse", {div_en, div_sign, mul_sign}, 64'd7);
        tick(); tick();
        #2 check("mulh_result", {resp_valid[1], resp_result[1]}, {1'b1, 32'hFFFF_FFFF});
        wait_resp(0, "div_wait");
        check("div_result", resp_result[0], 64'hFFFF_FFFD);
        tick();

        // Zero-operand divides on port 1
        e0 = den_cnt;
        req_valid = 2'b10; req_op[1] = 3'd4; req_src1[1] = 32'd5; req_src2[1] = 32'd0;
        #2 check("mod0_accept", 64'(req_ready), 64'd2);
        tick(); req_valid = '0;
        #2 check("mod0_not_early", 64'(resp_valid[1]), 64'd0);
        tick(); #2 check("mod0_result", {resp_valid[1], resp_result[1]}, {1'b1, 32'd0});
        tick();
        req_valid = 2'b10; req_op[1] = 3'd6; req_src1[1] = 32'd0; req_src2[1] = 32'd5;
        #2 check("modu0_accept", 64'(req_ready), 64'd2);
        tick(); req_valid = '0;
        tick(); #2 check("modu0_result", {resp_valid[1], resp_result[1]}, {1'b1, 32'd0});
        check("zero_no_div_en", 64'(den_cnt), 64'(e0));
        tick();
        check("div_ptr_pre", 64'(u_dut.u_div_arb.ptr_reg), 64'd0);

        // Both ports DIVU together
        e1 = cplt_cnt;
        req_valid = 2'b11;
        req_op[0] = 3'd5; req_src1[0] = 32'd100; req_src2[0] = 32'd7;
        req_op[1] = 3'd5; req_src1[1] = 32'd200; req_src2[1] = 32'd10;
        #2 check("divu_both_ready", 64'(req_ready), 64'd1);
        tick(); req_valid[0] = 1'b0;
        #2 check("divu_p0_en", {div_en, div_op1}, {1'b1, 32'd100});
        check("divu_p1_blocked", 64'(req_ready[1]), 64'd0);
        wait_ready(1, "divu_p1_wait");
        check("divu_p1_after_cplt", 64'(cplt_cnt), 64'(e1 + 1));
        check("divu_ptr_mid", 64'(u_dut.u_div_arb.ptr_reg), 64'd1);
        tick(); req_valid = '0;
        #2 check("divu_p1_en", {div_en, div_op1}, {1'b1, 32'd200});
        wait_resp(1, "divu_p1_resp");
        check("divu_results", resp_result, {32'd20, 32'd14});
        tick();
        check("divu_ptr_end", 64'(u_dut.u_div_arb.ptr_reg), 64'd0);

        // Port 0 DIV flushed mid-BUSY, port 1 DIV issued during drain
        r0 = rv0_cnt; e2 = cplt_cnt;
        req_valid = 2'b01; req_op[0] = 3'd3; req_src1[0] = 32'd100; req_src2[0] = 32'd7;
        #2 check("flush_div_accept", 64'(req_ready), 64'd1);
        tick(); req_valid = '0;
        tick(); flush = 2'b01;
        tick(); flush = '0;
        req_valid = 2'b10; req_op[1] = 3'd3; req_src1[1] = 32'd100; req_src2[1] = 32'd7;
        #2 check("drain_p1_blocked", 64'(req_ready), 64'd0);
        wait_ready(1, "drain_wait");
        check("drain_cplt_first", 64'(cplt_cnt), 64'(e2 + 1));
        tick(); req_valid = '0;
        #2 check("drain_p1_en", 64'(div_en), 64'd1);
        wait_resp(1, "drain_p1_resp");
        check("drain_p1_result", resp_result[1], 64'd14);
        check("flush_no_resp0", 64'(rv0_cnt), 64'(r0));
        tick();

        // Async reset while dividing with a held response on port 1
        resp_ready = '0;
        req_valid = 2'b10; req_op[1] = 3'd0; req_src1[1] = 32'd3; req_src2[1] = 32'd5;
        #2 check("rst_mul_accept", 64'(req_ready), 64'd2);
        tick();
        req_valid = 2'b01; req_op[0] = 3'd3; req_src1[0] = 32'd100; req_src2[0] = 32'd7;
        #2 check("rst_div_accept", 64'(req_ready), 64'd1);
        tick(); req_valid = '0;
        tick();
        #2 check("pre_rst_have", {resp_valid, resp_result[1]}, {2'b10, 32'd15});
        check("pre_rst_busy", 64'(u_dut.d_state_reg), 64'd2);
        #1 rst = 1'b1;
        #1 check("async_rst_resp", {resp_valid, 30'd0, div_en, div_sign}, 64'd0);
        check("async_rst_result", resp_result, 64'd0);
        check("async_rst_div_ops", {div_op1, div_op2}, 64'd0);
        check("async_rst_mul_ops", {mul_op1, mul_op2}, 64'd0);
        tick(); tick(); rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Schedules the shared multi-cycle arithmetic resources (one 2-cycle multiplier core, one iterative SRT divider core) between two issue pipes (port 0, port 1).
- Sits between the EX stages and the mul/div cores; the single-cycle ALU ops never pass through it.
- Per-unit round-robin arbitration, single outstanding op per port, valid/ready request/response handshakes, per-port flush.
- Handles zero-operand divides without touching the divider.

Parameters:
- NPORT, 2, number of requesters (fixed 2 in this revision).
- OPW, 3, width of req_op encoding.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port request accepted this cycle
- req_op  in  2xOPW  0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 MOD, 5 DIVU, 6 MODU, 7 reserved
- req_src1, req_src2  in  2x32  operands (rj, rk)
- flush  in  2  per-port kill of pending/in-flight op
- resp_valid  out  2  result available
- resp_ready  in  2  consumer takes result
- resp_result  out  2x32  result
- mul_op1, mul_op2  out  32  multiplier operands (0 when idle)
- mul_sign  out  1  signed multiply
- mul_out  in  64  multiplier product
- div_en  out  1  divider start pulse
- div_sign  out  1  signed divide
- div_op1, div_op2  out  32  divider operands, held until complete
- div_ready  in  1  divider idle
- div_complete  in  1  one-cycle pulse, rem/quo valid
- div_rem, div_quo  in  32  divider outputs

Behaviour:
- Reset: all state IDLE, resp_valid=0, resp_result=0, div_en=0, mul_op1/op2=0, mul_sign=0, div_op1/op2=0, div_sign=0, both RR pointers = port 0.
- Port state: FREE / WAIT / HAVE. req_ready[p] = FREE and the target unit grants p this cycle. Accepted request moves the port to WAIT; result capture moves it to HAVE. resp_valid[p] = HAVE. resp_valid & resp_ready returns the port to FREE; a new request on the same port is accepted no earlier than the next cycle.
- Arbitration is per unit. Both ports requesting the same free unit: grant goes to the RR pointer; the pointer flips to the other port after each grant. Ports requesting different units are both granted in the same cycle.
- Multiplier FSM M_IDLE -> M_EXEC -> M_IDLE:
  - Grant in cycle T latches the operands; mul_op*/mul_sign are driven in T+1 and T+2.
  - Captured at the end of T+2: MUL = mul_out[31:0]; MULH/MULHU = mul_out[63:32].
  - A new grant is allowed in T+2, giving one multiply every 2 cycles.
- Divider FSM D_IDLE, D_START, D_BUSY, D_DRAIN:
  - On grant with src2 == 0 or src1 == 0: no divider use; result 0 is captured at the end of the grant cycle +1; FSM stays in D_IDLE.
  - Otherwise D_IDLE -> D_START. The grant waits while div_ready = 0.
  - D_START: div_en = 1 for exactly one cycle, operands stable -> D_BUSY.
  - D_BUSY: on div_complete, capture div_quo for DIV/DIVU and div_rem for MOD/MODU -> D_IDLE.
- Flush:
  - Flush in the grant cycle cancels the grant; the RR pointer does not flip.
  - Flush in WAIT: the mul result is discarded. A divide in D_START/D_BUSY moves to D_DRAIN and stays there until div_complete, with the result dropped; no new divide is granted in D_DRAIN. The port returns to FREE the next cycle.
  - Flush in HAVE: resp_valid drops the next cycle.
  - Flush of port p never disturbs port 1-p.
- Simultaneous events: div_complete and flush in the same cycle means the result is dropped. resp handshake and a new req on the same port: the request is not accepted that cycle.
- req_op = 7 is never accepted; req_ready stays 0.
- Reset mid-operation clears everything asynchronously. The divider core is reset by the same rst.

Decomposition:
- Shared package holds:
  - op encodings (MD_MUL..MD_MODU);
  - port-state and divider-state constants (P_FREE/P_WAIT/P_HAVE; D_IDLE/D_START/D_BUSY/D_DRAIN);
  - MUL_LAT = 2.
- One sub-module, rr_arb2: two request lines, pointer register, grant and advance inputs. It is instantiated once per unit.

Test Plan:
- Port 0 MUL 0xFFFFFFFF x 0x2 with resp_ready=1 -> resp_result[0]=0xFFFFFFFE 3 cycles after the accept. MULHU same operands -> 0x00000001.
- Port 0 DIV and port 1 MULH in the same cycle -> both req_ready=1. Port 1 MULH 0x80000000 x 0x2 -> 0xFFFFFFFF. Port 0 DIV -7/2 -> quo 0xFFFFFFFD.
- Both ports DIVU in the same cycle, pointer=0:
  - port 0 is granted; port 1 waits for div_ready and then receives div_en;
  - pointer ends at port 0 after the two grants.
- Port 1 MOD src2=0 -> resp_result=0 with no div_en pulse. MODU 0/5 -> 0, no div_en.
- Port 0 DIV 100/7 flushed mid-BUSY:
  - no resp_valid[0];
  - a DIV from port 1 issued during the drain gets div_en only after div_complete;
  - its 100/7 result is 14.
- rst asserted during D_BUSY with resp_valid[1]=1 -> all outputs return to reset values immediately, asynchronously.
